// File: rtl/spi_master_seq_if.sv
// Control-side handshake plus SPI pins of the sequencer; master = sequencer, slave = its environment.
// No storage here; start is only honoured while busy is low, later requests are dropped.
interface spi_master_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             cs_n;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, cs_n
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_seq.sv
// SPI mode-0 frame sequencer: setup, WIDTH-bit shift, hold, gap; busy for (2*WIDTH+3)*DIVIDER cycles.
// No backpressure: start is sampled only in IDLE, requests while busy are dropped without queueing.
module spi_master_seq #(
    parameter int DIVIDER = 40,
    parameter int WIDTH   = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    spi_master_seq_if.master   bus
);
    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             done_q, done_d;

    logic             tc, sclk_rise, sclk_fall, last_bit;
    logic [WIDTH-1:0] tx_next;

    assign tc        = (cnt_q == CW'(DIVIDER - 1));
    assign sclk_rise = (state_q == SHIFT) && tc && !sclk_q;
    assign sclk_fall = (state_q == SHIFT) && tc && sclk_q;
    assign last_bit  = (bit_cnt_q == BW'(WIDTH - 1));
    assign tx_next   = tx_sh_q << 1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start)             state_d = SETUP;
            SETUP:   if (tc)                    state_d = SHIFT;
            SHIFT:   if (sclk_fall && last_bit) state_d = HOLD;
            HOLD:    if (tc)                    state_d = GAP;
            GAP:     if (tc)                    state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = (state_q == IDLE || tc) ? '0 : cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;

        if (state_q == IDLE && bus.start) begin
            tx_sh_d   = bus.tx_data;
            rx_sh_d   = '0;
            bit_cnt_d = '0;
            cs_n_d    = 1'b0;
            mosi_d    = bus.tx_data[WIDTH-1];
        end

        // mosi changes only on falling sclk so the slave sees it stable across the rising edge
        if (state_q == SHIFT && tc) begin
            sclk_d = ~sclk_q;
        end
        if (sclk_rise) begin
            rx_sh_d = (rx_sh_q << 1) | WIDTH'(bus.miso);
        end
        if (sclk_fall) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (!last_bit) begin
                tx_sh_d = tx_next;
                mosi_d  = tx_next[WIDTH-1];
            end
        end

        if (state_q == HOLD && tc) begin
            cs_n_d    = 1'b1;
            mosi_d    = 1'b0;
            rx_data_d = rx_sh_q;
            done_d    = 1'b1;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
endmodule

// File: tb/tb_spi_master_seq.sv
// Directed bench: WIDTH=8/DIVIDER=4 instance with loopback or shift-register slave, plus a WIDTH=1/DIVIDER=2 instance.
module tb_spi_master_seq;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    spi_master_seq_if #(.WIDTH(8)) bus8 ();
    spi_master_seq_if #(.WIDTH(1)) bus1 ();

    spi_master_seq #(.DIVIDER(4), .WIDTH(8)) u_dut (.clk(clk), .n_rst(n_rst), .bus(bus8));
    spi_master_seq #(.DIVIDER(2), .WIDTH(1)) u_dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));

    bit       loop;
    bit [7:0] slv_word;
    int       slv_idx = 0;

    // slave model: presents its word MSB first, advancing on each falling sclk
    always @(negedge bus8.sclk or posedge bus8.cs_n) begin
        if (bus8.cs_n) slv_idx <= 0;
        else           slv_idx <= slv_idx + 1;
    end

    assign bus8.miso = loop ? bus8.mosi : slv_word[3'(7 - slv_idx)];
    assign bus1.miso = bus1.mosi;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // observes one frame of bus8 from the cycle after the accept edge (k=1) until busy drops
    task automatic run_frame(input int poke_at, input logic [7:0] poke_tx,
                             output int t_rise, output int n_pulse, output int n_high,
                             output int max_run, output int t_done, output int n_done,
                             output int t_idle, output int t_csup, output bit mosi_lo);
        int   run;
        logic prev;
        run = 0; prev = 1'b0;
        t_rise = -1; n_pulse = 0; n_high = 0; max_run = 0;
        t_done = -1; n_done = 0; t_idle = -1; t_csup = -1; mosi_lo = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (bus8.sclk && !prev) begin
                n_pulse++;
                if (t_rise < 0) t_rise = k;
            end
            if (bus8.sclk) begin
                n_high++; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            prev = bus8.sclk;
            if (bus8.done) begin
                n_done++;
                if (t_done < 0) t_done = k;
            end
            if (bus8.cs_n && t_csup < 0) t_csup = k;
            if (!bus8.cs_n && !bus8.mosi) mosi_lo = 1'b1;
            if (!bus8.busy) begin
                t_idle = k;
                break;
            end
            if (k == poke_at) begin
                bus8.start   = 1'b1;
                bus8.tx_data = poke_tx;
            end else if (k == poke_at + 1) begin
                bus8.start = 1'b0;
            end
        end
    endtask

    task automatic launch8(input logic [7:0] data);
        bus8.start   = 1'b1;
        bus8.tx_data = data;
        @(posedge clk); #1;
        bus8.start = 1'b0;
    endtask

    int t_rise, n_pulse, n_high, max_run, t_done, n_done, t_idle, t_csup;
    int t_done_first, n_busy, n_p, n_d;
    bit mosi_lo;
    logic prev1;

    initial begin
        n_rst = 1'b0;
        loop = 1'b1;
        slv_word = 8'h00;
        bus8.start = 1'b0; bus8.tx_data = '0;
        bus1.start = 1'b0; bus1.tx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", bus8.cs_n, 1);
        chk("rst_sclk", bus8.sclk, 0);
        chk("rst_mosi", bus8.mosi, 0);
        chk("rst_busy", bus8.busy, 0);
        chk("rst_done", bus8.done, 0);
        chk("rst_rx", bus8.rx_data, 0);
        chk("rst1_cs_n", bus1.cs_n, 1);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // loopback 0xA5
        launch8(8'hA5);
        chk("t1_cs_low", bus8.cs_n, 0);
        chk("t1_busy", bus8.busy, 1);
        chk("t1_mosi_msb", bus8.mosi, 1);
        run_frame(-1, 8'h00, t_rise, n_pulse, n_high, max_run, t_done, n_done, t_idle, t_csup, mosi_lo);
        chk("t1_first_rise", t_rise, 8);
        chk("t1_pulses", n_pulse, 8);
        chk("t1_high_total", n_high, 32);
        chk("t1_high_run", max_run, 4);
        chk("t1_done_at", t_done, 72);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_busy_fall", t_idle, 76);
        chk("t1_rx", bus8.rx_data, 8'hA5);

        // slave returns 0x3C while master sends 0xFF
        loop = 1'b0;
        slv_word = 8'h3C;
        @(posedge clk); #1;
        launch8(8'hFF);
        run_frame(-1, 8'h00, t_rise, n_pulse, n_high, max_run, t_done, n_done, t_idle, t_csup, mosi_lo);
        chk("t2_rx", bus8.rx_data, 8'h3C);
        chk("t2_mosi_all_hi", mosi_lo, 0);
        chk("t2_mosi_after", bus8.mosi, 0);
        chk("t2_cs_after", bus8.cs_n, 1);
        loop = 1'b1;

        // start while busy is dropped
        @(posedge clk); #1;
        launch8(8'h5A);
        run_frame(20, 8'h11, t_rise, n_pulse, n_high, max_run, t_done, n_done, t_idle, t_csup, mosi_lo);
        chk("t3_done_cnt", n_done, 1);
        chk("t3_rx", bus8.rx_data, 8'h5A);
        n_busy = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus8.busy || !bus8.cs_n) n_busy++;
        end
        chk("t3_no_restart", n_busy, 0);

        // reset mid-shift, then a clean frame
        launch8(8'hC3);
        repeat (30) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("t4_cs_n", bus8.cs_n, 1);
        chk("t4_sclk", bus8.sclk, 0);
        chk("t4_mosi", bus8.mosi, 0);
        chk("t4_busy", bus8.busy, 0);
        chk("t4_done", bus8.done, 0);
        n_d = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus8.done) n_d++;
        end
        chk("t4_no_done", n_d, 0);
        chk("t4_rx_kept", bus8.rx_data, 8'h00);
        n_rst = 1'b1;
        @(posedge clk); #1;
        launch8(8'h81);
        run_frame(-1, 8'h00, t_rise, n_pulse, n_high, max_run, t_done, n_done, t_idle, t_csup, mosi_lo);
        chk("t4_rx_after", bus8.rx_data, 8'h81);
        chk("t4_done_cnt", n_done, 1);

        // start held high: back-to-back frames
        @(posedge clk); #1;
        bus8.start = 1'b1;
        bus8.tx_data = 8'h0F;
        @(posedge clk); #1;
        bus8.tx_data = 8'hF0;
        run_frame(-1, 8'h00, t_rise, n_pulse, n_high, max_run, t_done, n_done, t_idle, t_csup, mosi_lo);
        chk("t5_rx0", bus8.rx_data, 8'h0F);
        chk("t5_busy_len", t_idle, 76);
        t_done_first = t_done;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        chk("t5_reaccept", bus8.cs_n, 0);
        chk("t5_cs_gap", 77 - t_csup, 5);
        run_frame(-1, 8'h00, t_rise, n_pulse, n_high, max_run, t_done, n_done, t_idle, t_csup, mosi_lo);
        chk("t5_rx1", bus8.rx_data, 8'hF0);
        chk("t5_done_apart", 77 + t_done - t_done_first, 77);

        // WIDTH=1, DIVIDER=2 loopback
        bus1.start = 1'b1;
        bus1.tx_data = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        n_busy = 0; n_p = 0; n_d = 0; prev1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!bus1.busy) break;
            n_busy++;
            if (bus1.sclk && !prev1) n_p++;
            prev1 = bus1.sclk;
            if (bus1.done) n_d++;
            @(posedge clk); #1;
        end
        chk("t6_busy_len", n_busy, 10);
        chk("t6_pulses", n_p, 1);
        chk("t6_done_cnt", n_d, 1);
        chk("t6_rx", bus1.rx_data, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
